// File: rtl/scpad_pkg.sv
// scpad_pkg: shared widths, counts and in-flight entry type for the scratchpad body.
package scpad_pkg;
  localparam int NUM_FE    = 2;
  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 512;
  localparam int LANES     = 32;
  localparam int SRAM_LAT  = 2;
  localparam int RSP_DEPTH = SRAM_LAT + NUM_FE;
  localparam int FE_W      = (NUM_FE > 1) ? $clog2(NUM_FE) : 1;
  typedef logic [FE_W-1:0] fe_idx_t;
  typedef struct packed {
    logic    valid;
    fe_idx_t owner;
  } inflight_t;
  function automatic fe_idx_t fe_wrap_inc(input fe_idx_t i);
    return (int'(i) == NUM_FE - 1) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/scpad_rsp_fifo.sv
// scpad_rsp_fifo: per-frontend read response FIFO; head is zero while empty.
module scpad_rsp_fifo #(
  parameter int DW    = 512,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  always_comb begin
    wr_d  = push_i ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/scpad_body_sched.sv
// scpad_body_sched: round-robin arbiter of frontend vector requests onto one SRAM port,
// with fixed-latency read tracking and per-frontend response FIFOs.
module scpad_body_sched
  import scpad_pkg::*;
(
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_FE-1:0]              fe_req_valid_i,
  input  logic [NUM_FE-1:0]              fe_req_write_i,
  input  logic [NUM_FE-1:0][ADDR_W-1:0]  fe_req_addr_i,
  input  logic [NUM_FE-1:0][DATA_W-1:0]  fe_req_wdata_i,
  input  logic [NUM_FE-1:0][LANES-1:0]   fe_req_mask_i,
  output logic [NUM_FE-1:0]              fe_stall_o,
  output logic [NUM_FE-1:0]              fe_res_valid_o,
  output logic [NUM_FE-1:0][DATA_W-1:0]  fe_res_rdata_o,
  input  logic                           sram_ready_i,
  output logic                           sram_req_valid_o,
  output logic                           sram_req_write_o,
  output logic [ADDR_W-1:0]              sram_req_addr_o,
  output logic [DATA_W-1:0]              sram_req_wdata_o,
  output logic [LANES-1:0]               sram_req_mask_o,
  input  logic [DATA_W-1:0]              sram_rdata_i
);
  fe_idx_t            rr_q, rr_d, gidx, idx;
  logic               found;
  logic [NUM_FE-1:0]  grant, push, pop, full, empty;
  inflight_t          pipe_q [SRAM_LAT];
  inflight_t          pipe_d, tail;
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_FE; k++) begin
      idx = fe_idx_t'((int'(rr_q) + k) % NUM_FE);
      if (sram_ready_i && !found && fe_req_valid_i[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    grant  = found ? (NUM_FE'(1) << gidx) : '0;
    rr_d   = found ? fe_wrap_inc(gidx) : rr_q;
    pipe_d = '{valid: found & ~fe_req_write_i[gidx], owner: gidx};
  end
  assign sram_req_valid_o = found;
  assign sram_req_write_o = found & fe_req_write_i[gidx];
  assign sram_req_addr_o  = found ? fe_req_addr_i[gidx] : '0;
  assign sram_req_wdata_o = found ? fe_req_wdata_i[gidx] : '0;
  assign sram_req_mask_o  = found ? fe_req_mask_i[gidx] : '0;
  assign fe_stall_o       = fe_req_valid_i & ~grant;
  // The pipe mirrors the SRAM latency, so it shifts unconditionally.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_q <= '0;
      for (int k = 0; k < SRAM_LAT; k++) pipe_q[k] <= '0;
    end else begin
      rr_q      <= rr_d;
      pipe_q[0] <= pipe_d;
      for (int k = 1; k < SRAM_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end
  assign tail = pipe_q[SRAM_LAT-1];
  for (genvar g = 0; g < NUM_FE; g++) begin : g_rsp
    assign push[g]           = tail.valid && (tail.owner == fe_idx_t'(g));
    assign pop[g]            = fe_res_valid_o[g] & ~fe_stall_o[g];
    assign fe_res_valid_o[g] = ~empty[g];
    scpad_rsp_fifo #(.DW(DATA_W), .DEPTH(RSP_DEPTH)) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .wdata_i (sram_rdata_i),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .head_o  (fe_res_rdata_o[g])
    );
  end
  // Depth covers the round-robin worst case; overflow means a broken frontend contract.
  a_no_overflow: assert property (@(posedge clk) disable iff (!n_rst) (push & full) == '0);
endmodule

// File: tb/tb_scpad_body_sched.sv
// tb_scpad_body_sched: directed steps with per-frontend response scoreboard and an SRAM model.
module tb_scpad_body_sched;
  import scpad_pkg::*;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [NUM_FE-1:0]             fe_req_valid, fe_req_write, fe_stall, fe_res_valid;
  logic [NUM_FE-1:0][ADDR_W-1:0] fe_req_addr;
  logic [NUM_FE-1:0][DATA_W-1:0] fe_req_wdata, fe_res_rdata;
  logic [NUM_FE-1:0][LANES-1:0]  fe_req_mask;
  logic                          sram_ready, sram_req_valid, sram_req_write;
  logic [ADDR_W-1:0]             sram_req_addr;
  logic [DATA_W-1:0]             sram_req_wdata, sram_rdata;
  logic [LANES-1:0]              sram_req_mask;
  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] wdata;
  } req_t;
  req_t              req_q [NUM_FE][$];
  logic [DATA_W-1:0] exp_q [NUM_FE][$];
  int tests = 0;
  int fails = 0;
  logic [SRAM_LAT-1:0] rv = '0;
  logic [ADDR_W-1:0]   ra [SRAM_LAT];
  always #5 clk = ~clk;
  scpad_body_sched dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .fe_req_valid_i   (fe_req_valid),
    .fe_req_write_i   (fe_req_write),
    .fe_req_addr_i    (fe_req_addr),
    .fe_req_wdata_i   (fe_req_wdata),
    .fe_req_mask_i    (fe_req_mask),
    .fe_stall_o       (fe_stall),
    .fe_res_valid_o   (fe_res_valid),
    .fe_res_rdata_o   (fe_res_rdata),
    .sram_ready_i     (sram_ready),
    .sram_req_valid_o (sram_req_valid),
    .sram_req_write_o (sram_req_write),
    .sram_req_addr_o  (sram_req_addr),
    .sram_req_wdata_o (sram_req_wdata),
    .sram_req_mask_o  (sram_req_mask),
    .sram_rdata_i     (sram_rdata)
  );
  function automatic logic [DATA_W-1:0] rowdata(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    for (int k = 0; k < DATA_W / 32; k++) r[k*32 +: 32] = {3'b101, a, 16'(k)} ^ 32'h0BAD_0000;
    return r;
  endfunction
  function automatic req_t mk(input logic wr, input logic [ADDR_W-1:0] a,
                              input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.mask = m; r.wdata = d;
    return r;
  endfunction
  // Fixed-latency SRAM: read data appears SRAM_LAT cycles after an accepted read.
  always @(posedge clk) begin
    rv[0] <= sram_req_valid & sram_ready & ~sram_req_write;
    ra[0] <= sram_req_addr;
    for (int k = 1; k < SRAM_LAT; k++) begin
      rv[k] <= rv[k-1];
      ra[k] <= ra[k-1];
    end
  end
  assign sram_rdata = rv[SRAM_LAT-1] ? rowdata(ra[SRAM_LAT-1]) : {16{32'hDEAD_BEEF}};
  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < NUM_FE; i++) begin
      if (req_q[i].size() > 0) begin
        fe_req_valid[i] = 1'b1;
        fe_req_write[i] = req_q[i][0].wr;
        fe_req_addr[i]  = req_q[i][0].addr;
        fe_req_mask[i]  = req_q[i][0].mask;
        fe_req_wdata[i] = req_q[i][0].wdata;
      end else begin
        fe_req_valid[i] = 1'b0;
        fe_req_write[i] = 1'b0;
        fe_req_addr[i]  = '0;
        fe_req_mask[i]  = '0;
        fe_req_wdata[i] = '0;
      end
    end
  endtask
  task automatic adv();
    for (int i = 0; i < NUM_FE; i++) begin
      if (fe_req_valid[i] && !fe_stall[i]) begin
        if (!req_q[i][0].wr) exp_q[i].push_back(rowdata(req_q[i][0].addr));
        void'(req_q[i].pop_front());
      end
      if (fe_res_valid[i] && !fe_stall[i]) begin
        chk($sformatf("rsp_expected_fe%0d", i), exp_q[i].size() != 0, 1'b1);
        if (exp_q[i].size() != 0) chk($sformatf("rsp_data_fe%0d", i), fe_res_rdata[i], exp_q[i].pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
    drive();
    #1;
  endtask
  task automatic do_reset();
    n_rst = 1'b0;
    for (int i = 0; i < NUM_FE; i++) begin
      req_q[i].delete();
      exp_q[i].delete();
    end
    drive();
    #1;
    chk("rst_req_valid", sram_req_valid, 1'b0);
    chk("rst_res_valid", fe_res_valid, 2'b00);
    chk("rst_stall", fe_stall, 2'b00);
    chk("rst_rdata", |fe_res_rdata, 1'b0);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    sram_ready = 1'b1;
    drive();
    @(negedge clk);
    #1;
    do_reset();
    // single read latency
    req_q[0].push_back(mk(1'b0, 13'h010, '1, '0));
    drive();
    #1;
    chk("t1_req_valid", sram_req_valid, 1'b1);
    chk("t1_req_addr", sram_req_addr, 13'h010);
    chk("t1_req_write", sram_req_write, 1'b0);
    chk("t1_stall", fe_stall, 2'b00);
    adv();
    chk("t1_res_c1", fe_res_valid, 2'b00);
    chk("t1_req_c1", sram_req_valid, 1'b0);
    adv();
    chk("t1_res_c2", fe_res_valid, 2'b00);
    adv();
    chk("t1_res_c3", fe_res_valid, 2'b01);
    chk("t1_data", fe_res_rdata[0], rowdata(13'h010));
    adv();
    chk("t1_res_c4", fe_res_valid, 2'b00);
    // alternating round robin from reset
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_q[0].push_back(mk(1'b0, ADDR_W'(13'h100 + k), '1, '0));
      req_q[1].push_back(mk(1'b0, ADDR_W'(13'h200 + k), '1, '0));
    end
    drive();
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_stall%0d", k), fe_stall, (k == 7) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10));
      chk($sformatf("t2_addr%0d", k), sram_req_addr,
          (k % 2 == 1) ? ADDR_W'(13'h200 + k / 2) : ADDR_W'(13'h100 + k / 2));
      adv();
    end
    for (int k = 0; k < 8; k++) adv();
    chk("t2_drained", exp_q[0].size() + exp_q[1].size(), 0);
    // sram not ready holds the pointer
    req_q[0].push_back(mk(1'b0, 13'h2F0, '1, '0));
    drive();
    #1;
    for (int k = 0; k < 5; k++) adv();
    sram_ready = 1'b0;
    req_q[0].push_back(mk(1'b0, 13'h300, '1, '0));
    req_q[1].push_back(mk(1'b0, 13'h301, '1, '0));
    drive();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t3_stall%0d", k), fe_stall, 2'b11);
      chk($sformatf("t3_noreq%0d", k), sram_req_valid, 1'b0);
      adv();
    end
    sram_ready = 1'b1;
    #1;
    chk("t3_grant_fe1", fe_stall, 2'b01);
    chk("t3_addr_fe1", sram_req_addr, 13'h301);
    adv();
    chk("t3_grant_fe0", fe_stall, 2'b00);
    chk("t3_addr_fe0", sram_req_addr, 13'h300);
    for (int k = 0; k < 7; k++) adv();
    chk("t3_drained", exp_q[0].size() + exp_q[1].size(), 0);
    // masked write, no response
    req_q[0].push_back(mk(1'b1, 13'h1FFF, 32'h0000_FFFF, {16{32'h1234_5678}}));
    drive();
    #1;
    chk("t4_valid", sram_req_valid, 1'b1);
    chk("t4_write", sram_req_write, 1'b1);
    chk("t4_addr", sram_req_addr, 13'h1FFF);
    chk("t4_mask", sram_req_mask, 32'h0000_FFFF);
    chk("t4_wdata", sram_req_wdata, {16{32'h1234_5678}});
    adv();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_nores%0d", k), fe_res_valid, 2'b00);
      adv();
    end
    // responses held while the owner is stalled
    req_q[0].push_back(mk(1'b0, 13'h400, '1, '0));
    req_q[0].push_back(mk(1'b0, 13'h401, '1, '0));
    req_q[0].push_back(mk(1'b0, 13'h402, '1, '0));
    drive();
    #1;
    adv();
    adv();
    sram_ready = 1'b0;
    #1;
    adv();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_hold%0d", k), fe_res_valid[0], 1'b1);
      chk($sformatf("t5_stall%0d", k), fe_stall[0], 1'b1);
      chk($sformatf("t5_head%0d", k), fe_res_rdata[0], rowdata(13'h400));
      adv();
    end
    sram_ready = 1'b1;
    #1;
    chk("t5_unstall", fe_stall, 2'b00);
    adv();
    chk("t5_second_valid", fe_res_valid[0], 1'b1);
    chk("t5_second_head", fe_res_rdata[0], rowdata(13'h401));
    for (int k = 0; k < 6; k++) adv();
    chk("t5_drained", exp_q[0].size(), 0);
    // reset with reads in flight
    req_q[0].push_back(mk(1'b0, 13'h500, '1, '0));
    req_q[1].push_back(mk(1'b0, 13'h501, '1, '0));
    drive();
    #1;
    adv();
    adv();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t6_nostale%0d", k), fe_res_valid, 2'b00);
      adv();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
